// File: rtl/network_params.sv
// network_params: constants and types shared by the pooling scheduler slice.
//   pool_state_t      : scheduler FSM encoding (IDLE, ISSUE, DRAIN, DONE)
//   DEF_*             : default geometry and latency for the scheduler
//   nh_size / out_dim / cnt_w : helpers that derive neighborhood size,
//                       pooled-map dimensions and counter widths from the
//                       instance parameters
//   NUM_NH_LAYERS     : adder-tree depth macro; defaults to 2 when the build
//                       does not supply it
`ifndef NUM_NH_LAYERS
`define NUM_NH_LAYERS 2
`endif

package network_params;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } pool_state_t;

  localparam int DEF_FM_WIDTH      = 4;
  localparam int DEF_FM_HEIGHT     = 4;
  localparam int DEF_POOL_DIM      = 2;
  localparam int DEF_ADDR_BITWIDTH = 16;
  localparam int DEF_PIPE_LATENCY  = `NUM_NH_LAYERS;

  function automatic int nh_size(input int pool_dim);
    return pool_dim * pool_dim;
  endfunction

  function automatic int out_dim(input int fm_dim, input int pool_dim);
    return fm_dim / pool_dim;
  endfunction

  // Width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int NEIGHBORHOOD_SIZE = nh_size(DEF_POOL_DIM);
  localparam int DEF_OUT_WIDTH     = out_dim(DEF_FM_WIDTH, DEF_POOL_DIM);
  localparam int DEF_OUT_HEIGHT    = out_dim(DEF_FM_HEIGHT, DEF_POOL_DIM);

endpackage

// File: rtl/valid_delay.sv
// valid_delay: fixed-depth valid shift register modelling the registered
// adder tree.
//   clock   : rising-edge clock
//   reset   : asynchronous active-low reset, clears every stage
//   in_vld  : token entering the tree
//   out_vld : token leaving the tree, DEPTH cycles after in_vld
//   pending : a token sits in a stage that has not yet reached the output
module valid_delay #(
  parameter int DEPTH = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic in_vld,
  output logic out_vld,
  output logic pending
);

  if (DEPTH < 1) begin : g_bad_depth
    $error("valid_delay DEPTH must be at least 1");
  end

  logic [DEPTH-1:0] vld_sr;

  if (DEPTH == 1) begin : g_one
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) vld_sr <= '0;
      else        vld_sr <= in_vld;
    end
    assign pending = 1'b0;
  end else begin : g_many
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) vld_sr <= '0;
      else        vld_sr <= {vld_sr[DEPTH-2:0], in_vld};
    end
    // The output stage is excluded: that token completes this cycle.
    assign pending = |vld_sr[DEPTH-2:0];
  end

  assign out_vld = vld_sr[DEPTH-1];

endmodule

// File: rtl/pool_scheduler.sv
// pool_scheduler: walks a feature map in non-overlapping POOL_DIM x POOL_DIM
// windows (raster order, row-major inside a window), issuing one read per
// cycle and tracking each completed neighborhood through the adder tree to
// its pooled-map write.
//   clock, reset   : rising-edge clock, asynchronous active-low reset
//   start          : begins a pass (ignored unless idle)
//   pause          : suppresses new reads; in-flight tokens keep draining
//   rd_en, rd_addr : feature-map read strobe / address
//   load_en        : returned element is shifted into the neighborhood reg
//   nh_valid       : neighborhood complete, consumed by the adder tree
//   out_wr_en, out_addr : pooled result write strobe / address
//   busy, done     : not idle / end-of-pass pulse
//   perf_cycles    : busy-cycle counter, present only when POOL_PERF_CNT_EN
//                    is defined; tied to 0 otherwise
module pool_scheduler
  import network_params::*;
#(
  parameter int FM_WIDTH      = DEF_FM_WIDTH,
  parameter int FM_HEIGHT     = DEF_FM_HEIGHT,
  parameter int POOL_DIM      = DEF_POOL_DIM,
  parameter int ADDR_BITWIDTH = DEF_ADDR_BITWIDTH,
  parameter int PIPE_LATENCY  = DEF_PIPE_LATENCY
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     pause,
  output logic                     rd_en,
  output logic [ADDR_BITWIDTH-1:0] rd_addr,
  output logic                     load_en,
  output logic                     nh_valid,
  output logic                     out_wr_en,
  output logic [ADDR_BITWIDTH-1:0] out_addr,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              perf_cycles
);

  localparam int NH_SIZE = nh_size(POOL_DIM);
  localparam int OUT_W   = out_dim(FM_WIDTH, POOL_DIM);
  localparam int OUT_H   = out_dim(FM_HEIGHT, POOL_DIM);
  localparam int NUM_OUT = OUT_W * OUT_H;
  localparam int PD_W    = cnt_w(POOL_DIM);
  localparam int WC_W    = cnt_w(OUT_W);
  localparam int WR_W    = cnt_w(OUT_H);
  localparam int OA_W    = cnt_w(NUM_OUT);

  if (FM_WIDTH % POOL_DIM != 0) begin : g_bad_w
    $error("FM_WIDTH must be a multiple of POOL_DIM");
  end
  if (FM_HEIGHT % POOL_DIM != 0) begin : g_bad_h
    $error("FM_HEIGHT must be a multiple of POOL_DIM");
  end
  if (NH_SIZE < 1) begin : g_bad_pool
    $error("POOL_DIM must be at least 1");
  end

  pool_state_t state, state_nxt;

  logic [PD_W-1:0] col_p0, row_p0;
  logic [WC_W-1:0] wcol_p0;
  logic [WR_W-1:0] wrow_p0;
  logic            start_acc, elem_last, pass_last, in_flight;
  logic            vld_p1, win_end_p1, vld_p2, pend_tail;
  logic [OA_W-1:0] oaddr;

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign start_acc = (state == ST_IDLE) && start;
  assign rd_en     = (state == ST_ISSUE) && !pause;

  assign elem_last = (col_p0 == PD_W'(POOL_DIM - 1)) && (row_p0 == PD_W'(POOL_DIM - 1));
  assign pass_last = elem_last && (wcol_p0 == WC_W'(OUT_W - 1)) && (wrow_p0 == WR_W'(OUT_H - 1));
  assign in_flight = vld_p1 || vld_p2 || pend_tail;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start) state_nxt = ST_ISSUE;
      ST_ISSUE: if (rd_en && pass_last) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!in_flight) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Stage p0: window/element counters, advanced once per issued read
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_p0  <= '0;
      row_p0  <= '0;
      wcol_p0 <= '0;
      wrow_p0 <= '0;
    end else if (start_acc) begin
      col_p0  <= '0;
      row_p0  <= '0;
      wcol_p0 <= '0;
      wrow_p0 <= '0;
    end else if (rd_en) begin
      if (col_p0 == PD_W'(POOL_DIM - 1)) begin
        col_p0 <= '0;
        if (row_p0 == PD_W'(POOL_DIM - 1)) begin
          row_p0 <= '0;
          if (wcol_p0 == WC_W'(OUT_W - 1)) begin
            wcol_p0 <= '0;
            if (wrow_p0 == WR_W'(OUT_H - 1)) wrow_p0 <= '0;
            else                             wrow_p0 <= wrow_p0 + 1'b1;
          end else begin
            wcol_p0 <= wcol_p0 + 1'b1;
          end
        end else begin
          row_p0 <= row_p0 + 1'b1;
        end
      end else begin
        col_p0 <= col_p0 + 1'b1;
      end
    end
  end

  assign rd_addr = (ADDR_BITWIDTH'(wrow_p0) * ADDR_BITWIDTH'(POOL_DIM) + ADDR_BITWIDTH'(row_p0))
                   * ADDR_BITWIDTH'(FM_WIDTH)
                 + ADDR_BITWIDTH'(wcol_p0) * ADDR_BITWIDTH'(POOL_DIM) + ADDR_BITWIDTH'(col_p0);

  // Stage p1: memory returns data (load_en); p2: neighborhood complete
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p1     <= 1'b0;
      win_end_p1 <= 1'b0;
      vld_p2     <= 1'b0;
    end else begin
      vld_p1     <= rd_en;
      win_end_p1 <= rd_en && elem_last;
      vld_p2     <= win_end_p1;
    end
  end

  assign load_en  = vld_p1;
  assign nh_valid = vld_p2;

  // Stage p3..: adder tree; its output valid is the write strobe
  valid_delay #(
    .DEPTH (PIPE_LATENCY)
  ) u_valid_delay (
    .clock   (clock),
    .reset   (reset),
    .in_vld  (vld_p2),
    .out_vld (out_wr_en),
    .pending (pend_tail)
  );

  // Pooled-map address saturates at the last output so it never wraps mid-pass.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                        oaddr <= '0;
    else if (start_acc)                                oaddr <= '0;
    else if (out_wr_en && oaddr != OA_W'(NUM_OUT - 1)) oaddr <= oaddr + 1'b1;
  end

  assign out_addr = ADDR_BITWIDTH'(oaddr);

`ifdef POOL_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)         perf_q <= '0;
    else if (start_acc) perf_q <= '0;
    else if (busy)      perf_q <= perf_q + 32'd1;
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_pool_scheduler.sv
// Scoreboard bench for pool_scheduler (4x4 map, 2x2 pooling, latency 2).
// Stimulus pushes the expected read / nh_valid / write / done events with
// their cycle numbers (cycle 0 = cycle in which start is high); a negedge
// monitor pops and compares whenever the DUT raises a strobe.
module tb_pool_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        rd_en, load_en, nh_valid, out_wr_en, busy, done;
  logic [15:0] rd_addr, out_addr;
  logic [31:0] perf_cycles;

`ifdef POOL_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  always #5 clock = ~clock;

  pool_scheduler #(
    .FM_WIDTH      (4),
    .FM_HEIGHT     (4),
    .POOL_DIM      (2),
    .ADDR_BITWIDTH (16),
    .PIPE_LATENCY  (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .pause       (pause),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .load_en     (load_en),
    .nh_valid    (nh_valid),
    .out_wr_en   (out_wr_en),
    .out_addr    (out_addr),
    .busy        (busy),
    .done        (done),
    .perf_cycles (perf_cycles)
  );

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  ev_t rd_q[$];
  ev_t nh_q[$];
  ev_t wr_q[$];
  ev_t dn_q[$];

  int checks   = 0;
  int failures = 0;
  int gcyc     = 0;
  int base     = 0;
  logic prev_rd  = 1'b0;
  logic prev_rst = 1'b0;

  // Hand-derived raster/row-major read order for a 4x4 map in 2x2 windows.
  int addr_tab [16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input int rel, input int val);
    checks++;
    failures++;
    $display("FAIL %s cycle=%0d value=%0d required=no event", name, rel, val);
  endtask

  always @(posedge clock) gcyc <= gcyc + 1;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin : monitor
    ev_t e;
    int  rel;
    rel = gcyc - base;
    if (reset && prev_rst) chk("load_en_follows_rd_en", 32'(load_en), 32'(prev_rd));
    if (rd_en) begin
      if (rd_q.size() == 0) unexpected("rd_unexpected", rel, int'(rd_addr));
      else begin
        e = rd_q.pop_front();
        chk("rd_cycle", rel, e.cyc);
        chk("rd_addr", 32'(rd_addr), e.val);
      end
    end
    if (nh_valid) begin
      if (nh_q.size() == 0) unexpected("nh_unexpected", rel, 1);
      else begin
        e = nh_q.pop_front();
        chk("nh_cycle", rel, e.cyc);
      end
    end
    if (out_wr_en) begin
      if (wr_q.size() == 0) unexpected("wr_unexpected", rel, int'(out_addr));
      else begin
        e = wr_q.pop_front();
        chk("wr_cycle", rel, e.cyc);
        chk("out_addr", 32'(out_addr), e.val);
      end
    end
    if (done) begin
      if (dn_q.size() == 0) unexpected("done_unexpected", rel, 1);
      else begin
        e = dn_q.pop_front();
        chk("done_cycle", rel, e.cyc);
      end
    end
    prev_rd  = rd_en;
    prev_rst = reset;
  end

  // Expected events of one pass: reads start in cycle 1, skipping paused
  // cycles p_lo..p_hi; nh_valid 2 cycles after a window's last read, write
  // 2 cycles later, done 1 cycle after the final write. Only events before
  // cycle 'cutoff' are expected.
  task automatic push_pass(input int p_lo, input int p_hi, input int cutoff);
    ev_t e;
    int  t;
    int  last_out;
    t = 1;
    last_out = 0;
    for (int i = 0; i < 16; i++) begin
      while (t >= p_lo && t <= p_hi) t++;
      if (t < cutoff) begin
        e.cyc = t; e.val = addr_tab[i]; rd_q.push_back(e);
      end
      if (i % 4 == 3) begin
        if (t + 2 < cutoff) begin
          e.cyc = t + 2; e.val = 1; nh_q.push_back(e);
        end
        if (t + 4 < cutoff) begin
          e.cyc = t + 4; e.val = i / 4; wr_q.push_back(e);
        end
        last_out = t + 4;
      end
      t++;
    end
    if (last_out + 1 < cutoff) begin
      e.cyc = last_out + 1; e.val = 1; dn_q.push_back(e);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rd_en"},       32'(rd_en),     0);
    chk({tag, "_rd_addr"},     32'(rd_addr),   0);
    chk({tag, "_load_en"},     32'(load_en),   0);
    chk({tag, "_nh_valid"},    32'(nh_valid),  0);
    chk({tag, "_out_wr_en"},   32'(out_wr_en), 0);
    chk({tag, "_out_addr"},    32'(out_addr),  0);
    chk({tag, "_busy"},        32'(busy),      0);
    chk({tag, "_done"},        32'(done),      0);
    chk({tag, "_perf_cycles"}, perf_cycles,    0);
  endtask

  task automatic run_pass(input string tag, input int p_lo, input int p_hi,
                          input int restart_cyc, input int rst_cyc, input int perf_exp);
    int rel;
    tick;
    start = 1'b1;
    base  = gcyc;
    tick;
    start = 1'b0;
    for (int k = 0; k < 34; k++) begin
      rel   = gcyc - base;
      pause = (rel >= p_lo && rel <= p_hi);
      start = (rel == restart_cyc);
      if (rel == rst_cyc) begin
        reset = 1'b0;
        #2;
        check_zero({tag, "_midreset"});
      end
      if (rel == rst_cyc + 2) reset = 1'b1;
      tick;
    end
    pause = 1'b0;
    start = 1'b0;
    chk({tag, "_busy_after"}, 32'(busy), 0);
    chk({tag, "_perf_after"}, perf_cycles, perf_exp);
    chk({tag, "_rd_left"},    rd_q.size(), 0);
    chk({tag, "_nh_left"},    nh_q.size(), 0);
    chk({tag, "_wr_left"},    wr_q.size(), 0);
    chk({tag, "_done_left"},  dn_q.size(), 0);
    rd_q.delete();
    nh_q.delete();
    wr_q.delete();
    dn_q.delete();
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) tick;
    check_zero("reset");
    reset = 1'b1;
    tick;
    tick;

    push_pass(100, 0, 1000);
    run_pass("basic", 100, 0, -1, -1, PERF_ON ? 21 : 0);

    push_pass(3, 5, 1000);
    run_pass("pause", 3, 5, -1, -1, PERF_ON ? 24 : 0);

    push_pass(100, 0, 1000);
    run_pass("restart", 100, 0, 10, -1, PERF_ON ? 21 : 0);

    push_pass(100, 0, 9);
    run_pass("midreset", 100, 0, -1, 9, 0);

    push_pass(100, 0, 1000);
    run_pass("after_reset", 100, 0, -1, -1, PERF_ON ? 21 : 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
